// File: rtl/definition.sv
// Shared definitions for the PE array.
//   width : operand width of the activation/filter streams; psums are 2*width.
package definition;
  localparam int width = 8;
endpackage

// File: rtl/pe_mac.sv
// pe_mac: one processing element of a PE row. It is a registered adder
// that adds the row-broadcast product to the upstream partial sum.
// Ports:
//   clk    : clock, rising edge
//   rstn   : synchronous active-low clear (wins over en)
//   en     : hold when low
//   i_prod : broadcast product r_q*f_q
//   i_psum : partial sum from the previous PE (0 for PE0)
//   o_psum : registered partial sum to the next PE
module pe_mac #(
  parameter int pw = 2 * definition::width
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          en,
  input  logic [pw-1:0] i_prod,
  input  logic [pw-1:0] i_psum,
  output logic [pw-1:0] o_psum
);

  // The sum wraps modulo 2^pw; the row has no carry-out.
  always_ff @(posedge clk) begin
    if (!rstn)   o_psum <= '0;
    else if (en) o_psum <= i_psum + i_prod;
  end

endmodule

// File: rtl/pe_row8.sv
// pe_row8: a row of 8 MAC PEs. Registered i_r/i_f are multiplied once and
// broadcast to every PE. Partial sums ripple PE0 -> PE7, one PE per cycle, so
// o_psum is the moving sum of the last 8 sampled products.
// Ports:
//   clk    : clock, rising edge
//   rstn   : synchronous active-low reset (clears inputs regs and all PEs)
//   en     : global enable; all registers hold when low
//   i_r    : activation operand, unsigned
//   i_f    : filter operand, unsigned
//   o_psum : row partial sum taken straight from the PE7 register
module pe_row8 #(
  parameter int width = definition::width
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               en,
  input  logic [width-1:0]   i_r,
  input  logic [width-1:0]   i_f,
  output logic [2*width-1:0] o_psum
);

  localparam int N_PE = 8;
  localparam int PW   = 2 * width;

  logic [width-1:0]         r_q, f_q;
  logic [PW-1:0]            prod;
  logic [N_PE:0][PW-1:0]    chain;

  // Input stage. Because this register is gated by en, X on the inputs while
  // en is low never reaches the datapath.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_q <= '0;
      f_q <= '0;
    end else if (en) begin
      r_q <= i_r;
      f_q <= i_f;
    end
  end

  // A full-width product cannot overflow PW bits.
  assign prod     = PW'(r_q) * PW'(f_q);
  assign chain[0] = '0;

  generate
    for (genvar k = 0; k < N_PE; k++) begin : g_pe
      pe_mac #(.pw(PW)) u_pe (
        .clk    (clk),
        .rstn   (rstn),
        .en     (en),
        .i_prod (prod),
        .i_psum (chain[k]),
        .o_psum (chain[k+1])
      );
    end
  endgenerate

  assign o_psum = chain[N_PE];

endmodule

// File: tb/tb_pe_row8.sv
// Directed and random checks for pe_row8 (width = 8).
module tb_pe_row8;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rstn;
  logic           en;
  logic [W-1:0]   i_r, i_f;
  logic [2*W-1:0] o_psum;

  int n_chk  = 0;
  int n_pass = 0;

  // Products sampled on enabled edges since the last reset, oldest first.
  int unsigned hist[$];

  logic [15:0] ew [11] = '{16'd1, 16'd5, 16'd14, 16'd14, 16'd14, 16'd14,
                           16'd14, 16'd14, 16'd13, 16'd9, 16'd0};
  logic [7:0]  rv [12] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8,
                           8'd0, 8'd0, 8'd0, 8'd0};
  logic [7:0]  fv [12] = '{8'd1, 8'd2, 8'd3, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0,
                           8'd0, 8'd0, 8'd0, 8'd0};
  logic [15:0] mx [8]  = '{16'd65025, 16'd64514, 16'd64003, 16'd63492,
                           16'd62981, 16'd62470, 16'd61959, 16'd61448};

  always #5 clk = ~clk;

  pe_row8 #(.width(W)) dut (
    .clk    (clk),
    .rstn   (rstn),
    .en     (en),
    .i_r    (i_r),
    .i_f    (i_f),
    .o_psum (o_psum)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Closed form: after edge m, sum of products sampled at edges m-1 .. m-8.
  function automatic logic [15:0] model_sum();
    int unsigned s = 0;
    for (int i = 2; i <= 9; i++)
      if (hist.size() >= i) s += hist[hist.size() - i];
    return s[15:0];
  endfunction

  // Called at a negedge: drive inputs, take one rising edge, return at negedge.
  task automatic cyc(input logic rs, input logic e, input logic [W-1:0] r, input logic [W-1:0] f);
    rstn = rs;
    en   = e;
    i_r  = r;
    i_f  = f;
    @(posedge clk);
    if (!rs)    hist.delete();
    else if (e) hist.push_back(int'(r) * int'(f));
    @(negedge clk);
  endtask

  initial begin
    rstn = 1'b0; en = 1'b1; i_r = '0; i_f = '0;
    @(negedge clk);

    // Reset with live inputs, then release with zeros.
    repeat (2) begin
      cyc(1'b0, 1'b1, 8'($urandom), 8'($urandom));
      chk("rst_hold", o_psum, 16'd0);
    end
    repeat (3) begin
      cyc(1'b1, 1'b1, 8'd0, 8'd0);
      chk("rst_release", o_psum, 16'd0);
    end

    // Basic window.
    for (int i = 0; i < 12; i++) begin
      cyc(1'b1, 1'b1, rv[i], fv[i]);
      if (i >= 1) chk("window", o_psum, ew[i-1]);
    end

    // Same window with a 3-edge freeze on the plateau, X on i_r meanwhile.
    cyc(1'b0, 1'b1, 8'd0, 8'd0);
    chk("rst_again", o_psum, 16'd0);
    for (int i = 0; i < 12; i++) begin
      cyc(1'b1, 1'b1, rv[i], fv[i]);
      if (i >= 1) chk("freeze_win", o_psum, ew[i-1]);
      if (i == 5) begin
        repeat (3) begin
          cyc(1'b1, 1'b0, 8'hxx, 8'($urandom));
          chk("freeze_hold", o_psum, 16'd14);
        end
      end
    end

    // Max operands: wraps modulo 2^16.
    cyc(1'b1, 1'b1, 8'd255, 8'd255);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b1, 8'd255, 8'd255);
      chk("max_ramp", o_psum, mx[i]);
    end
    repeat (2) begin
      cyc(1'b1, 1'b1, 8'd255, 8'd255);
      chk("max_plateau", o_psum, 16'd61448);
    end

    // Reset with a full nonzero window, then resume from empty.
    cyc(1'b0, 1'b1, 8'd255, 8'd255);
    chk("rst_mid", o_psum, 16'd0);
    cyc(1'b1, 1'b1, 8'd3, 8'd3);
    chk("rst_resume0", o_psum, 16'd0);
    cyc(1'b1, 1'b1, 8'd0, 8'd0);
    chk("rst_resume1", o_psum, 16'd9);
    cyc(1'b1, 1'b1, 8'd0, 8'd0);
    chk("rst_resume2", o_psum, 16'd9);

    // Random stream against the closed-form model.
    repeat (1000) begin
      cyc(1'b1, ($urandom_range(0, 9) < 8), 8'($urandom), 8'($urandom));
      chk("rand", o_psum, model_sum());
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
